// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and counter terminal value.
// Imported by sub_serial and fsub_bit.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SUB_WIDTH_DEF = 8;
    localparam int SUB_LAST_DEF  = SUB_WIDTH_DEF - 1;

    // Bit index of the final subtract step for a given operand width.
    function automatic int last_count(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/fsub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column needs to borrow.
// Purely combinational, no latency, no backpressure.
module fsub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: latches a/b on a start, emits a-b LSB first into out.
// Latency: done rises WIDTH+1 cycles after start; en is ignored while subtracting, acks in DONE.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter  int WIDTH = SUB_WIDTH_DEF,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    localparam logic [CW-1:0] LAST = CW'(last_count(WIDTH));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             diff_bit;
    logic             borrow_nxt;

    fsub_bit u_fsub_bit (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (diff_bit),
        .bout (borrow_nxt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    a_d      = a;
                    b_d      = b;
                    out_d    = '0;
                    count_d  = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    assign out    = out_q;
    assign borrow = borrow_q;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial at WIDTH=8 and WIDTH=16 against a behavioural model.
module tb_sub_serial;

    logic        clk;
    logic        rst;
    logic        en8, en16;
    logic [7:0]  a8, b8, out8;
    logic [15:0] a16, b16, out16;
    logic        borrow8, done8, borrow16, done16;

    int nchecks = 0;
    int nerr    = 0;

    sub_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
        .out(out8), .borrow(borrow8), .done(done8)
    );

    sub_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16),
        .out(out16), .borrow(borrow16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 busy (result not yet valid), 2 result presented.
    // The expected result is plain modular arithmetic on the operands captured at start.
    int          m8_mode, m8_left, m16_mode, m16_left;
    logic [7:0]  m8_out;
    logic [15:0] m16_out;
    logic        m8_b, m16_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_mode <= 0; m8_left <= 0; m8_out <= '0; m8_b <= 1'b0;
        end else begin
            case (m8_mode)
                0: if (en8) begin
                    m8_out <= a8 - b8; m8_b <= (a8 < b8); m8_left <= 8; m8_mode <= 1;
                end
                1: begin
                    if (m8_left == 1) m8_mode <= 2;
                    m8_left <= m8_left - 1;
                end
                default: if (en8) m8_mode <= 0;
            endcase
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16_mode <= 0; m16_left <= 0; m16_out <= '0; m16_b <= 1'b0;
        end else begin
            case (m16_mode)
                0: if (en16) begin
                    m16_out <= a16 - b16; m16_b <= (a16 < b16); m16_left <= 16; m16_mode <= 1;
                end
                1: begin
                    if (m16_left == 1) m16_mode <= 2;
                    m16_left <= m16_left - 1;
                end
                default: if (en16) m16_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp_done8", {31'd0, done8}, {31'd0, m8_mode == 2});
        if (m8_mode != 1) begin
            chk("cmp_out8", {24'd0, out8}, {24'd0, m8_out});
            chk("cmp_borrow8", {31'd0, borrow8}, {31'd0, m8_b});
        end
        chk("cmp_done16", {31'd0, done16}, {31'd0, m16_mode == 2});
        if (m16_mode != 1) begin
            chk("cmp_out16", {16'd0, out16}, {16'd0, m16_out});
            chk("cmp_borrow16", {31'd0, borrow16}, {31'd0, m16_b});
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
        int         cyc;
        logic [7:0] eo;
        @(negedge clk);
        a8 = a; b8 = b; en8 = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            en8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cyc++;
        end while (!done8 && cyc < 40);
        eo = a - b;
        chk("lat8", cyc, 9);
        chk("out8", {24'd0, out8}, {24'd0, eo});
        chk("borrow8", {31'd0, borrow8}, {31'd0, a < b});
        repeat (hold) begin
            @(negedge clk);
            chk("hold_done8", {31'd0, done8}, 32'd1);
            chk("hold_out8", {24'd0, out8}, {24'd0, eo});
        end
        en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int          cyc;
        logic [15:0] eo;
        @(negedge clk);
        a16 = a; b16 = b; en16 = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            en16 = 1'b0;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cyc++;
        end while (!done16 && cyc < 60);
        eo = a - b;
        chk("lat16", cyc, 17);
        chk("out16", {16'd0, out16}, {16'd0, eo});
        chk("borrow16", {31'd0, borrow16}, {31'd0, a < b});
        en16 = 1'b1;
        @(negedge clk);
        en16 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, last, rises;
        logic prev;
        rst = 1'b1; en8 = 1'b0; en16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out8", {24'd0, out8}, 32'd0);
        chk("rst_borrow8", {31'd0, borrow8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        rst = 1'b0;

        run8(8'd100, 8'd37, 3);
        run8(8'd5, 8'd7, 0);
        chk("lit_5m7", {24'd0, out8}, 32'd254);
        run8(8'd0, 8'd1, 0);
        chk("lit_0m1", {24'd0, out8}, 32'd255);
        run8(8'hAA, 8'hAA, 0);
        chk("lit_eq_borrow", {31'd0, borrow8}, 32'd0);
        run8(8'd255, 8'd0, 0);
        chk("lit_255m0", {24'd0, out8}, 32'd255);

        // en held high: each result is presented for one cycle, then a new start follows.
        @(negedge clk);
        en8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
        cyc = 0; last = -1; rises = 0; prev = 1'b0;
        while (rises < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done8 && !prev) begin
                if (last >= 0) chk("b2b_period", cyc - last, 10);
                chk("b2b_out", {24'd0, out8}, 32'd145);
                last = cyc;
                rises++;
            end
            prev = done8;
        end
        if (rises < 4) chk("b2b_rises", rises, 4);
        @(negedge clk);
        en8 = 1'b0;

        // Asynchronous reset in the middle of a subtraction.
        @(negedge clk);
        a8 = 8'd77; b8 = 8'd12; en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out8", {24'd0, out8}, 32'd0);
        chk("midrst_borrow8", {31'd0, borrow8}, 32'd0);
        chk("midrst_done8", {31'd0, done8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run8(8'd9, 8'd3, 1);
        chk("lit_9m3", {24'd0, out8}, 32'd6);

        fork
            begin
                repeat (1000) run8(8'($urandom), 8'($urandom), 0);
            end
            begin
                repeat (1000) run16(16'($urandom), 16'($urandom));
            end
        join

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
